// File: rtl/vid_out_lock_ctrl.sv
// Lock/recovery controller for an AXI4-Stream-to-video output bridge and its timing generator.
// Optional lock-timeout feature compiled in by defining VOC_LOCK_TIMEOUT_EN.
module vid_out_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        locked,
    input  logic        wr_error,
    input  logic        vtg_fsync,
    input  logic        clr_err,
    output logic        bridge_rst,
    output logic        vtg_en,
    output logic [1:0]  ctrl_state,
    output logic [7:0]  err_count,
    output logic [15:0] frame_count,
    output logic        irq,
    output logic        irq_pending
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESET     = 2'd1,
        ST_WAIT_LOCK = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  rst_cnt_reg, rst_cnt_next;
    logic [7:0]  err_count_reg, err_count_next;
    logic [15:0] frame_count_reg, frame_count_next;
    logic        irq_reg, irq_pending_reg, irq_pending_next;
    logic        bridge_rst_reg, bridge_rst_next;
    logic        vtg_en_reg, vtg_en_next;
    logic        recover;
    logic        lock_timeout;

`ifdef VOC_LOCK_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] lock_timer_reg, lock_timer_next;

    // Timer restarts from zero on every entry to WAIT_LOCK.
    always_comb begin
        lock_timer_next = 24'd0;
        if (state_reg == ST_WAIT_LOCK && state_next == ST_WAIT_LOCK)
            lock_timer_next = lock_timer_reg + 24'd1;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst)
            lock_timer_reg <= 24'd0;
        else
            lock_timer_reg <= lock_timer_next;
    end

    assign lock_timeout = (state_reg == ST_WAIT_LOCK) && (lock_timer_reg == TIMEOUT_LAST);
`else
    // No timer: WAIT_LOCK holds until locked; TIMEOUT_CYCLES is accepted but has no effect.
    if (TIMEOUT_CYCLES >= 0) begin : g_no_timeout
        assign lock_timeout = 1'b0;
    end else begin : g_no_timeout_neg
        assign lock_timeout = 1'b0;
    end
`endif

    always_comb begin
        state_next = state_reg;
        recover    = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:      state_next = ST_RESET;
                ST_RESET:     if (rst_cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (locked) begin
                        state_next = ST_RUN;
                    end else if (lock_timeout) begin
                        state_next = ST_RESET;
                        recover    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked || wr_error) begin
                        state_next = ST_RESET;
                        recover    = 1'b1;
                    end
                end
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Counter only runs while staying in RESET, so each entry starts a full hold.
    always_comb begin
        rst_cnt_next = 8'd0;
        if (state_reg == ST_RESET && state_next == ST_RESET)
            rst_cnt_next = rst_cnt_reg + 8'd1;
    end

    always_comb begin
        err_count_next   = err_count_reg;
        irq_pending_next = irq_pending_reg;
        if (clr_err) begin
            err_count_next   = 8'd0;
            irq_pending_next = 1'b0;
        end else if (recover) begin
            irq_pending_next = 1'b1;
            if (err_count_reg != 8'hFF)
                err_count_next = err_count_reg + 8'd1;
        end
    end

    always_comb begin
        frame_count_next = frame_count_reg;
        if (state_reg == ST_RUN && vtg_fsync)
            frame_count_next = frame_count_reg + 16'd1;
    end

    assign bridge_rst_next = (state_next == ST_IDLE) || (state_next == ST_RESET);
    assign vtg_en_next     = (state_next == ST_WAIT_LOCK) || (state_next == ST_RUN);

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            rst_cnt_reg     <= 8'd0;
            err_count_reg   <= 8'd0;
            frame_count_reg <= 16'd0;
            irq_reg         <= 1'b0;
            irq_pending_reg <= 1'b0;
            bridge_rst_reg  <= 1'b1;
            vtg_en_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rst_cnt_reg     <= rst_cnt_next;
            err_count_reg   <= err_count_next;
            frame_count_reg <= frame_count_next;
            irq_reg         <= recover;
            irq_pending_reg <= irq_pending_next;
            bridge_rst_reg  <= bridge_rst_next;
            vtg_en_reg      <= vtg_en_next;
        end
    end

    assign ctrl_state  = state_reg;
    assign bridge_rst  = bridge_rst_reg;
    assign vtg_en      = vtg_en_reg;
    assign err_count   = err_count_reg;
    assign frame_count = frame_count_reg;
    assign irq         = irq_reg;
    assign irq_pending = irq_pending_reg;

endmodule

// File: tb/tb_vid_out_lock_ctrl.sv
// Bench for vid_out_lock_ctrl: directed scenarios plus random traffic, checked every cycle
// against a state/cycle-count reference model of the controller's behaviour.
module tb_vid_out_lock_ctrl;

    localparam int RST_N = 16;
    localparam int TO_N  = 100;
`ifdef VOC_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_RESET = 1, S_WAIT = 2, S_RUN = 3;

    logic        aclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0, locked = 1'b0, wr_error = 1'b0, vtg_fsync = 1'b0, clr_err = 1'b0;
    logic        bridge_rst, vtg_en, irq, irq_pending;
    logic [1:0]  ctrl_state;
    logic [7:0]  err_count;
    logic [15:0] frame_count;

    vid_out_lock_ctrl #(.RST_CYCLES(RST_N), .TIMEOUT_CYCLES(TO_N)) dut (
        .aclk(aclk), .rst(rst), .enable(enable), .locked(locked), .wr_error(wr_error),
        .vtg_fsync(vtg_fsync), .clr_err(clr_err), .bridge_rst(bridge_rst), .vtg_en(vtg_en),
        .ctrl_state(ctrl_state), .err_count(err_count), .frame_count(frame_count),
        .irq(irq), .irq_pending(irq_pending)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model: current state, cycles already spent in it, and the visible counters.
    int m_state, m_in_state, m_err, m_frames, m_irq, m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_in_state = 0; m_err = 0; m_frames = 0; m_irq = 0; m_pend = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit ev;
        nxt = m_state;
        ev  = 1'b0;
        if (!enable) nxt = S_IDLE;
        else if (m_state == S_IDLE) nxt = S_RESET;
        else if (m_state == S_RESET && m_in_state + 1 == RST_N) nxt = S_WAIT;
        else if (m_state == S_WAIT && locked) nxt = S_RUN;
        else if (m_state == S_WAIT && TO_EN && m_in_state + 1 == TO_N) begin nxt = S_RESET; ev = 1'b1; end
        else if (m_state == S_RUN && (!locked || wr_error)) begin nxt = S_RESET; ev = 1'b1; end
        if (m_state == S_RUN && vtg_fsync) m_frames = (m_frames + 1) % 65536;
        m_irq = ev;
        if (clr_err) begin
            m_err = 0; m_pend = 0;
        end else if (ev) begin
            m_err  = (m_err == 255) ? 255 : m_err + 1;
            m_pend = 1;
        end
        m_in_state = (nxt == m_state) ? m_in_state + 1 : 0;
        m_state    = nxt;
    endtask

    task automatic check_all();
        chk("state", 32'(ctrl_state), m_state);
        chk("bridge_rst", 32'(bridge_rst), (m_state == S_IDLE || m_state == S_RESET) ? 1 : 0);
        chk("vtg_en", 32'(vtg_en), (m_state == S_WAIT || m_state == S_RUN) ? 1 : 0);
        chk("err_count", 32'(err_count), m_err);
        chk("frame_count", 32'(frame_count), m_frames);
        chk("irq", 32'(irq), m_irq);
        chk("irq_pending", 32'(irq_pending), m_pend);
    endtask

    task automatic tick();
        @(posedge aclk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40 && ctrl_state != 2'd3; i++) tick();
        chk("wait_run", 32'(ctrl_state), S_RUN);
    endtask

    initial begin
        int rcnt, wcnt;
        model_reset();

        // Power-up: reset for 5 cycles, enable, lock appears at cycle 30.
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b0; enable = 1'b1;
        rcnt = 0;
        for (int c = 5; c < 70; c++) begin
            if (c == 30) locked = 1'b1;
            tick();
            if (ctrl_state == 2'd1) rcnt++;
        end
        chk("pwr_reset_cycles", rcnt, RST_N);
        chk("pwr_run", 32'(ctrl_state), S_RUN);
        chk("pwr_err", 32'(err_count), 0);

        // Frames: 70000 pulses in RUN wrap to 4464; pulses in IDLE are ignored.
        vtg_fsync = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        vtg_fsync = 1'b0;
        tick();
        chk("frames_wrap", 32'(frame_count), 4464);
        enable = 1'b0;
        tick();
        vtg_fsync = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        vtg_fsync = 1'b0;
        chk("frames_idle", 32'(frame_count), 4464);
        enable = 1'b1;
        wait_run();

        // Lock loss for one cycle.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        chk("loss_irq", 32'(irq), 1);
        chk("loss_err", 32'(err_count), 1);
        chk("loss_pend", 32'(irq_pending), 1);
        rcnt = (ctrl_state == 2'd1) ? 1 : 0;
        tick();
        chk("loss_irq_gone", 32'(irq), 0);
        if (ctrl_state == 2'd1) rcnt++;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ctrl_state == 2'd1) rcnt++;
        end
        chk("loss_reset_cycles", rcnt, RST_N);

        // Saturation: 300 more wr_error events, then clear coincident with event 301.
        for (int k = 0; k < 300; k++) begin
            wait_run();
            wr_error = 1'b1;
            tick();
            wr_error = 1'b0;
        end
        chk("sat_err", 32'(err_count), 255);
        wait_run();
        wr_error = 1'b1; clr_err = 1'b1;
        tick();
        wr_error = 1'b0; clr_err = 1'b0;
        chk("clr_err", 32'(err_count), 0);
        chk("clr_pend", 32'(irq_pending), 0);
        chk("clr_irq", 32'(irq), 1);

        // Priority: enable=0 beats wr_error in RUN.
        wait_run();
        wr_error = 1'b1;
        tick();
        wr_error = 1'b0;
        wait_run();
        enable = 1'b0; wr_error = 1'b1;
        tick();
        wr_error = 1'b0;
        chk("prio_state", 32'(ctrl_state), S_IDLE);
        chk("prio_err", 32'(err_count), 1);
        chk("prio_irq", 32'(irq), 0);

        // Asynchronous reset in the middle of RESET, observed before any clock edge.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_reset_state", 32'(ctrl_state), S_RESET);
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(ctrl_state), S_IDLE);
        chk("async_bridge_rst", 32'(bridge_rst), 1);
        chk("async_vtg_en", 32'(vtg_en), 0);
        chk("async_err", 32'(err_count), 0);
        chk("async_frames", 32'(frame_count), 0);
        chk("async_irq", 32'(irq), 0);
        chk("async_pend", 32'(irq_pending), 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Lock never arrives.
        locked = 1'b0;
        for (int i = 0; i < 40 && ctrl_state != 2'd2; i++) tick();
        chk("to_reach_wait", 32'(ctrl_state), S_WAIT);
        if (TO_EN) begin
            wcnt = 1;
            for (int i = 0; i < 300 && ctrl_state == 2'd2; i++) begin
                tick();
                if (ctrl_state == 2'd2) wcnt++;
            end
            chk("to_wait_cycles", wcnt, TO_N);
            chk("to_state", 32'(ctrl_state), S_RESET);
            chk("to_err", 32'(err_count), 1);
        end else begin
            for (int i = 0; i < 10000; i++) tick();
            chk("no_to_state", 32'(ctrl_state), S_WAIT);
            chk("no_to_err", 32'(err_count), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 31) != 0);
            locked    = ($urandom_range(0, 9) < 8);
            wr_error  = ($urandom_range(0, 15) == 0);
            vtg_fsync = $urandom_range(0, 1) == 1;
            clr_err   = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
